// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754 adder/subtractor with a start/done handshake.
// Exponent and mantissa widths are parameters (fp16 by default, fp32 by override).
// Rounding is round-to-nearest-even. Subnormal inputs are flushed to zero.
// Results that would be subnormal underflow to a signed zero.
// The latency is a fixed 5 cycles from START to DONE, including all exceptional inputs.
module fp_addsub_seq #(
    parameter int EXP_W  = 5,
    parameter int MANT_W = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  SUB,
    input  logic [EXP_W+MANT_W:0] A,
    input  logic [EXP_W+MANT_W:0] B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [EXP_W+MANT_W:0] Q,
    output logic [4:0]            FLAGS
);
    // Handshake: START/SUB/A/B are sampled on a rising edge only when the block is
    // in IDLE or DONE (BUSY=0). While BUSY=1, START is ignored and is not queued.
    // DONE is a one-cycle pulse. Q/FLAGS become valid in the DONE cycle and are held
    // until the next DONE or until RST. RST overrides everything and drops any
    // START seen in the same cycle.

    localparam int W      = 1 + EXP_W + MANT_W;
    localparam int SIG_W  = MANT_W + 4;          // {1, mant, guard, round, sticky}
    localparam int EXT_EW = EXP_W + 8;           // signed exponent with room for the LZC shift
    localparam int LZ_W   = $clog2(SIG_W + 1);

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
    localparam logic signed [EXT_EW-1:0] EXP_ONE  = EXT_EW'(1);
    localparam logic signed [EXT_EW-1:0] EXP_ALL1 = EXT_EW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ALIGN, ST_ADD, ST_NORM, ST_ROUND, ST_DONE
    } state_t;

    state_t state_q, state_d;
    logic   accept;

    // Latched operands
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic         sub_q, sub_d;

    // ALIGN outputs
    logic                     exc_q, exc_d;
    logic [W-1:0]             exc_res_q, exc_res_d;
    logic [4:0]               exc_flg_q, exc_flg_d;
    logic                     sign_q, sign_d;
    logic                     eff_sub_q, eff_sub_d;
    logic signed [EXT_EW-1:0] exp_q, exp_d;
    logic [SIG_W-1:0]         big_q, big_d, small_q, small_d;

    // ADD / NORM outputs
    logic [SIG_W:0]           sum_q, sum_d;
    logic [SIG_W-1:0]         sig_q, sig_d;
    logic signed [EXT_EW-1:0] nexp_q, nexp_d;

    // Result registers
    logic [W-1:0] q_q, q_d;
    logic [4:0]   flags_q, flags_d;

    // ALIGN decode signals
    logic               a_sign, b_sign, eff_sub;
    logic [EXP_W-1:0]   a_exp, b_exp, big_exp, small_exp, exp_diff;
    logic [MANT_W-1:0]  a_man, b_man, big_man, small_man;
    logic               a_zero, a_inf, a_nan, a_snan;
    logic               b_zero, b_inf, b_nan, b_snan;
    logic               a_ge_b, sticky_lost;
    logic [SIG_W-1:0]   big_sig, small_sig, small_sh;
    int                 diff_i, shamt;
    logic               exc_hit;
    logic [W-1:0]       exc_val;
    logic [4:0]         exc_fl;

    // NORM / ROUND signals
    logic [LZ_W-1:0]          lzc;
    logic                     g_bit, r_bit, s_bit, lsb_bit, rup;
    logic [MANT_W:0]          rnd;
    logic signed [EXT_EW-1:0] rexp;
    logic [W-1:0]             res;
    logic [4:0]               res_fl;

    // State register; reset forces IDLE and so aborts any operation in flight
    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: a fixed walk through the pipeline stages
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (START) state_d = ST_ALIGN;
            ST_ALIGN: state_d = ST_ADD;
            ST_ADD:   state_d = ST_NORM;
            ST_NORM:  state_d = ST_ROUND;
            ST_ROUND: state_d = ST_DONE;
            ST_DONE:  state_d = START ? ST_ALIGN : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: busy while in a working stage, done pulse, start acceptance
    always_comb begin
        BUSY   = (state_q == ST_ALIGN) || (state_q == ST_ADD) ||
                 (state_q == ST_NORM)  || (state_q == ST_ROUND);
        DONE   = (state_q == ST_DONE);
        accept = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    // Capture the operands and the mode when a request is accepted
    always_comb begin
        a_d   = accept ? A   : a_q;
        b_d   = accept ? B   : b_q;
        sub_d = accept ? SUB : sub_q;
    end

    // ALIGN: classify the operands, force exceptional results, swap, align the smaller one
    always_comb begin
        a_sign = a_q[W-1];
        a_exp  = a_q[W-2:MANT_W];
        a_man  = a_q[MANT_W-1:0];
        b_sign = b_q[W-1] ^ sub_q;
        b_exp  = b_q[W-2:MANT_W];
        b_man  = b_q[MANT_W-1:0];

        a_zero = (a_exp == '0);
        a_inf  = (a_exp == {EXP_W{1'b1}}) && (a_man == '0);
        a_nan  = (a_exp == {EXP_W{1'b1}}) && (a_man != '0);
        a_snan = a_nan && !a_man[MANT_W-1];
        b_zero = (b_exp == '0);
        b_inf  = (b_exp == {EXP_W{1'b1}}) && (b_man == '0);
        b_nan  = (b_exp == {EXP_W{1'b1}}) && (b_man != '0);
        b_snan = b_nan && !b_man[MANT_W-1];

        eff_sub = a_sign ^ b_sign;

        // The exponent sits above the mantissa, so the packed compare orders magnitudes
        a_ge_b    = (a_q[W-2:0] >= b_q[W-2:0]);
        big_exp   = a_ge_b ? a_exp : b_exp;
        big_man   = a_ge_b ? a_man : b_man;
        small_exp = a_ge_b ? b_exp : a_exp;
        small_man = a_ge_b ? b_man : a_man;
        exp_diff  = big_exp - small_exp;

        // Shifting by MANT_W+3 already parks the hidden one in the sticky slot
        diff_i = int'(exp_diff);
        shamt  = (diff_i > MANT_W + 3) ? MANT_W + 3 : diff_i;

        big_sig     = {1'b1, big_man, 3'b000};
        small_sig   = {1'b1, small_man, 3'b000};
        sticky_lost = |(small_sig & ~({SIG_W{1'b1}} << shamt));
        small_sh    = (small_sig >> shamt) | {{(SIG_W-1){1'b0}}, sticky_lost};

        exc_hit = 1'b0;
        exc_val = '0;
        exc_fl  = '0;
        if (a_nan || b_nan) begin
            exc_hit = 1'b1;
            exc_val = QNAN;
            exc_fl  = {a_snan || b_snan, 4'b0000};
        end else if (a_inf && b_inf && eff_sub) begin
            exc_hit = 1'b1;
            exc_val = QNAN;
            exc_fl  = 5'b10000;
        end else if (a_inf) begin
            exc_hit = 1'b1;
            exc_val = a_q;
        end else if (b_inf) begin
            exc_hit = 1'b1;
            exc_val = {b_sign, b_q[W-2:0]};
        end else if (a_zero && b_zero) begin
            exc_hit = 1'b1;
            exc_val = {a_sign & b_sign, {(W-1){1'b0}}};
        end else if (a_zero) begin
            exc_hit = 1'b1;
            exc_val = {b_sign, b_q[W-2:0]};
        end else if (b_zero) begin
            exc_hit = 1'b1;
            exc_val = a_q;
        end

        exc_d     = exc_q;
        exc_res_d = exc_res_q;
        exc_flg_d = exc_flg_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        exp_d     = exp_q;
        big_d     = big_q;
        small_d   = small_q;
        if (state_q == ST_ALIGN) begin
            exc_d     = exc_hit;
            exc_res_d = exc_val;
            exc_flg_d = exc_fl;
            sign_d    = a_ge_b ? a_sign : b_sign;
            eff_sub_d = eff_sub;
            exp_d     = $signed({{(EXT_EW-EXP_W){1'b0}}, big_exp});
            big_d     = big_sig;
            small_d   = small_sh;
        end
    end

    // ADD: magnitude sum or difference; the larger operand is always on the left
    always_comb begin
        sum_d = sum_q;
        if (state_q == ST_ADD) begin
            if (eff_sub_q) sum_d = {1'b0, big_q} - {1'b0, small_q};
            else           sum_d = {1'b0, big_q} + {1'b0, small_q};
        end
    end

    // NORM: carry shifts right once; otherwise a leading-zero count shifts left
    always_comb begin
        lzc = '0;
        for (int i = 0; i < SIG_W; i++) begin
            if (sum_q[i]) lzc = LZ_W'(SIG_W - 1 - i);
        end

        sig_d  = sig_q;
        nexp_d = nexp_q;
        if (state_q == ST_NORM) begin
            if (sum_q[SIG_W]) begin
                sig_d  = {sum_q[SIG_W:2], sum_q[1] | sum_q[0]};
                nexp_d = exp_q + EXP_ONE;
            end else begin
                // An all-zero sum stays zero here, and ROUND reads that as exact cancellation
                sig_d  = sum_q[SIG_W-1:0] << lzc;
                nexp_d = exp_q - $signed({{(EXT_EW-LZ_W){1'b0}}, lzc});
            end
        end
    end

    // ROUND: RNE, range checks, final result selection
    always_comb begin
        lsb_bit = sig_q[3];
        g_bit   = sig_q[2];
        r_bit   = sig_q[1];
        s_bit   = sig_q[0];
        rup     = g_bit & (r_bit | s_bit | lsb_bit);
        rnd     = {1'b0, sig_q[SIG_W-2:3]} + {{MANT_W{1'b0}}, rup};
        rexp    = nexp_q + $signed({{(EXT_EW-1){1'b0}}, rnd[MANT_W]});

        res    = '0;
        res_fl = '0;
        if (exc_q) begin
            res    = exc_res_q;
            res_fl = exc_flg_q;
        end else if (!sig_q[SIG_W-1]) begin
            res    = '0;
            res_fl = '0;
        end else if (nexp_q < EXP_ONE) begin
            res    = {sign_q, {(W-1){1'b0}}};
            res_fl = 5'b00011;
        end else if (rexp >= EXP_ALL1) begin
            res    = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            res_fl = 5'b00101;
        end else begin
            res    = {sign_q, rexp[EXP_W-1:0], rnd[MANT_W-1:0]};
            res_fl = {4'b0000, g_bit | r_bit | s_bit};
        end

        q_d     = (state_q == ST_ROUND) ? res    : q_q;
        flags_d = (state_q == ST_ROUND) ? res_fl : flags_q;
    end

    // Datapath and result registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            exc_q     <= 1'b0;
            exc_res_q <= '0;
            exc_flg_q <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            exp_q     <= '0;
            big_q     <= '0;
            small_q   <= '0;
            sum_q     <= '0;
            sig_q     <= '0;
            nexp_q    <= '0;
            q_q       <= '0;
            flags_q   <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            sub_q     <= sub_d;
            exc_q     <= exc_d;
            exc_res_q <= exc_res_d;
            exc_flg_q <= exc_flg_d;
            sign_q    <= sign_d;
            eff_sub_q <= eff_sub_d;
            exp_q     <= exp_d;
            big_q     <= big_d;
            small_q   <= small_d;
            sum_q     <= sum_d;
            sig_q     <= sig_d;
            nexp_q    <= nexp_d;
            q_q       <= q_d;
            flags_q   <= flags_d;
        end
    end

    assign Q     = q_q;
    assign FLAGS = flags_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: an fp16 vector table, handshake/reset sequences, one fp32 case.
module tb_fp_addsub_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // fp16 instance
    logic        start, sub, busy, done;
    logic [15:0] a, b, q;
    logic [4:0]  flags;

    // fp32 instance
    logic        start32, sub32, busy32, done32;
    logic [31:0] a32, b32, q32;
    logic [4:0]  flags32;

    fp_addsub_seq dut (
        .CLK(clk), .RST(rst), .START(start), .SUB(sub), .A(a), .B(b),
        .BUSY(busy), .DONE(done), .Q(q), .FLAGS(flags)
    );

    fp_addsub_seq #(.EXP_W(8), .MANT_W(23)) dut32 (
        .CLK(clk), .RST(rst), .START(start32), .SUB(sub32), .A(a32), .B(b32),
        .BUSY(busy32), .DONE(done32), .Q(q32), .FLAGS(flags32)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] q;
        logic [4:0]  fl;
    } vec_t;

    localparam int N_VEC = 20;
    vec_t vecs[N_VEC];

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    string       cur_name = "none";
    logic [20:0] exp_q[$];   // expected {Q, FLAGS} per DONE pulse

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
        end
    endtask

    // Every DONE pulse must match the oldest expected result
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_done (%s): DONE seen with no operation outstanding", cur_name);
            end else begin
                check({cur_name, "_result"}, {11'b0, q, flags}, {11'b0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver ----------------
    // Drives one request and waits for DONE; lat counts cycles from the START cycle.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tsub,
                          input bit now, output int lat, output int busy_cnt);
        if (!now) @(negedge clk);
        a = ta;
        b = tb_v;
        sub = tsub;
        start = 1'b1;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the test finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, done_cnt, done_at;

        vecs[0]  = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 5'b00000};
        vecs[1]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 5'b00000};
        vecs[2]  = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 5'b00000};
        vecs[3]  = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 5'b00001};
        vecs[4]  = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 5'b00001};
        vecs[5]  = '{16'h3C00, 16'h0C00, 1'b0, 16'h3C00, 5'b00001};
        vecs[6]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 5'b00101};
        vecs[7]  = '{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 5'b10000};
        vecs[8]  = '{16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 5'b10000};
        vecs[9]  = '{16'h0400, 16'h03FF, 1'b1, 16'h0400, 5'b00000};
        vecs[10] = '{16'h0401, 16'h0400, 1'b1, 16'h0000, 5'b00011};
        vecs[11] = '{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 5'b00000};
        vecs[12] = '{16'h3C00, 16'hBC00, 1'b0, 16'h0000, 5'b00000};
        vecs[13] = '{16'h0000, 16'h3C00, 1'b1, 16'hBC00, 5'b00000};
        vecs[14] = '{16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 5'b00000};
        vecs[15] = '{16'h7E00, 16'h7C00, 1'b0, 16'h7E00, 5'b00000};
        vecs[16] = '{16'h3C00, 16'h3C01, 1'b0, 16'h4000, 5'b00001};
        vecs[17] = '{16'h3C03, 16'h3C00, 1'b0, 16'h4002, 5'b00001};
        vecs[18] = '{16'h3FFF, 16'h1000, 1'b0, 16'h4000, 5'b00001};
        vecs[19] = '{16'h3C00, 16'h4000, 1'b1, 16'hBC00, 5'b00000};

        rst = 1'b1;
        start = 1'b0; sub = 1'b0; a = '0; b = '0;
        start32 = 1'b0; sub32 = 1'b0; a32 = '0; b32 = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset_busy",  {31'b0, busy},  32'd0);
        check("reset_done",  {31'b0, done},  32'd0);
        check("reset_q",     {16'b0, q},     32'd0);
        check("reset_flags", {27'b0, flags}, 32'd0);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < N_VEC; i++) begin
            cur_name = $sformatf("vec%0d", i);
            exp_q.push_back({vecs[i].q, vecs[i].fl});
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b0, lat, bc);
            check({cur_name, "_latency"}, lat, 32'd5);
            if (i == 0) check("vec0_busy_cycles", bc, 32'd4);
        end

        // START two cycles after an accepted START is ignored
        cur_name = "ignored_start";
        exp_q.push_back({16'h4000, 5'b00000});
        @(negedge clk);
        a = 16'h3C00; b = 16'h3C00; sub = 1'b0; start = 1'b1;
        done_cnt = 0;
        done_at  = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
            start = (c == 2);
            a = 16'h7C00;
            b = 16'hFC00;
        end
        check("ignored_start_done_count", done_cnt, 32'd1);
        check("ignored_start_latency", done_at, 32'd5);

        // Back-to-back: START in the DONE cycle
        cur_name = "b2b_first";
        exp_q.push_back({16'h4000, 5'b00000});
        run_op(16'h3C00, 16'h3C00, 1'b0, 1'b0, lat, bc);
        check("b2b_first_latency", lat, 32'd5);
        cur_name = "b2b_second";
        exp_q.push_back({16'h3C02, 5'b00001});
        run_op(16'h3C01, 16'h1000, 1'b0, 1'b1, lat, bc);
        check("b2b_second_latency", lat, 32'd5);

        // Reset in NORM aborts the operation
        cur_name = "rst_in_norm";
        @(negedge clk);
        a = 16'h3C00; b = 16'h3C00; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;   // ALIGN
        @(negedge clk);                 // ADD
        @(negedge clk);                 // NORM
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_norm_busy",  {31'b0, busy},  32'd0);
        check("rst_norm_done",  {31'b0, done},  32'd0);
        check("rst_norm_q",     {16'b0, q},     32'd0);
        check("rst_norm_flags", {27'b0, flags}, 32'd0);
        repeat (8) @(negedge clk);

        // RST and START together: START dropped
        cur_name = "rst_with_start";
        a = 16'h3C00; b = 16'h3C00; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", {31'b0, busy}, 32'd0);
        repeat (8) @(negedge clk);

        // Operation after reset completes normally
        cur_name = "after_reset";
        exp_q.push_back({16'h3C00, 5'b00000});
        run_op(16'h4000, 16'h3C00, 1'b1, 1'b0, lat, bc);
        check("after_reset_latency", lat, 32'd5);
        @(negedge clk);

        // fp32 instance
        cur_name = "fp32";
        a32 = 32'h3F800000; b32 = 32'h40000000; sub32 = 1'b0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        lat = 1;
        while (done32 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("fp32_q", q32, 32'h40400000);
        check("fp32_flags", {27'b0, flags32}, 32'd0);
        check("fp32_latency", lat, 32'd5);

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
